// File: rtl/rs_pkg.sv
// Shared definitions for the register-slice skid buffer: FSM state encoding and
// default payload width.
package rs_pkg;

   localparam int unsigned PayloadLenDefault = 67;

   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StBusy  = 2'd1,
      StFull  = 2'd2
   } rs_state_e;

endpackage

// File: rtl/rs_skid_buffer_if.sv
// Upstream/downstream handshake bundle for rs_skid_buffer. The slave modport is
// the slice itself; master is whoever drives the slice (producer and consumer).
interface rs_skid_buffer_if #(
   parameter int unsigned payload_len = rs_pkg::PayloadLenDefault
);

   logic                   s_valid;
   logic                   s_ready;
   logic [payload_len-1:0] s_data;
   logic                   m_valid;
   logic                   m_ready;
   logic [payload_len-1:0] m_data;
   logic [1:0]             occupancy;

   modport slave (
      input  s_valid,
      output s_ready,
      input  s_data,
      output m_valid,
      input  m_ready,
      output m_data,
      output occupancy
   );

   modport master (
      output s_valid,
      input  s_ready,
      output s_data,
      input  m_valid,
      output m_ready,
      input  m_data,
      input  occupancy
   );

endinterface

// File: rtl/rs_data_reg.sv
// Payload register with load enable and asynchronous clear; holds its value
// whenever load is low.
module rs_data_reg #(
   parameter int unsigned Width = 67
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             load,
   input  logic [Width-1:0] d,
   output logic [Width-1:0] q
);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/rs_skid_buffer.sv
// Two-entry register slice: main entry drives m_data, skid entry absorbs the beat
// accepted while the consumer stalls. All handshake outputs come from flops.
module rs_skid_buffer
   import rs_pkg::*;
#(
   parameter int unsigned payload_len = PayloadLenDefault
) (
   input logic              clk,
   input logic              rstn,
   rs_skid_buffer_if.slave  bus
);

   rs_state_e              state_q, state_d;
   logic                   s_ready_q;
   logic                   m_valid;
   logic [1:0]             occupancy;
   logic                   up_xfer, dn_xfer;
   logic                   main_load, skid_load;
   logic [payload_len-1:0] main_d, main_q, skid_q;

   assign up_xfer = bus.s_valid & s_ready_q;
   assign dn_xfer = bus.m_ready & m_valid;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= StEmpty;
         s_ready_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         // Held low through reset so s_ready rises on the first edge after release.
         s_ready_q <= (state_d != StFull);
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StEmpty: if (up_xfer) state_d = StBusy;
         StBusy: begin
            if (up_xfer && !dn_xfer) begin
               state_d = StFull;
            end else if (!up_xfer && dn_xfer) begin
               state_d = StEmpty;
            end
         end
         StFull:  if (dn_xfer) state_d = StBusy;
         default: state_d = StEmpty;
      endcase
   end

   always_comb begin
      m_valid   = 1'b0;
      occupancy = 2'd0;
      unique case (state_q)
         StEmpty: begin
            m_valid   = 1'b0;
            occupancy = 2'd0;
         end
         StBusy: begin
            m_valid   = 1'b1;
            occupancy = 2'd1;
         end
         StFull: begin
            m_valid   = 1'b1;
            occupancy = 2'd2;
         end
         default: begin
            m_valid   = 1'b0;
            occupancy = 2'd0;
         end
      endcase
   end

   // Entry select: fresh input goes to main unless main is stalled, then to skid;
   // draining FULL promotes skid into main.
   always_comb begin
      main_load = 1'b0;
      skid_load = 1'b0;
      main_d    = bus.s_data;
      unique case (state_q)
         StEmpty: main_load = up_xfer;
         StBusy: begin
            main_load = up_xfer & dn_xfer;
            skid_load = up_xfer & ~dn_xfer;
         end
         StFull: begin
            main_load = dn_xfer;
            main_d    = skid_q;
         end
         default: ;
      endcase
   end

   rs_data_reg #(
      .Width (payload_len)
   ) u_main (
      .clk  (clk),
      .rstn (rstn),
      .load (main_load),
      .d    (main_d),
      .q    (main_q)
   );

   rs_data_reg #(
      .Width (payload_len)
   ) u_skid (
      .clk  (clk),
      .rstn (rstn),
      .load (skid_load),
      .d    (bus.s_data),
      .q    (skid_q)
   );

   assign bus.s_ready   = s_ready_q;
   assign bus.m_valid   = m_valid;
   assign bus.m_data    = main_q;
   assign bus.occupancy = occupancy;

endmodule

// File: tb/tb_rs_skid_buffer.sv
// Directed and randomised checks of rs_skid_buffer: reset, streaming, backpressure,
// FULL input ignore, async mid-operation reset and a scoreboarded random run.
module tb_rs_skid_buffer;

   localparam int W = 67;

   logic clk;
   logic rstn;
   int   checks = 0;
   int   errors = 0;

   logic [W-1:0] sb[$];
   logic [W-1:0] exp_data;
   logic         sr_before;

   rs_skid_buffer_if #(.payload_len(W)) rs_bus ();

   rs_skid_buffer #(
      .payload_len (W)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (rs_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic state_chk(input string tag, input logic mv, input logic sr, input logic [1:0] occ);
      chk({tag, "_m_valid"}, rs_bus.m_valid, mv);
      chk({tag, "_s_ready"}, rs_bus.s_ready, sr);
      chk({tag, "_occupancy"}, rs_bus.occupancy, occ);
   endtask

   // Drive one upstream beat at the falling edge; it is taken at the next rising edge.
   task automatic send(input logic [W-1:0] d);
      @(negedge clk);
      rs_bus.s_valid = 1'b1;
      rs_bus.s_data  = d;
   endtask

   initial begin
      rstn           = 1'b0;
      rs_bus.s_valid = 1'b0;
      rs_bus.s_data  = '0;
      rs_bus.m_ready = 1'b0;

      // Reset release
      repeat (3) begin
         @(negedge clk);
         state_chk("in_reset", 1'b0, 1'b0, 2'd0);
      end
      rstn = 1'b1;
      #1;
      chk("release_before_edge_s_ready", rs_bus.s_ready, 1'b0);
      @(negedge clk);
      state_chk("after_release", 1'b0, 1'b1, 2'd0);

      // Streaming 0x1..0x10 with consumer always ready
      rs_bus.m_ready = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         if (i > 1) begin
            exp_data = W'(i - 1);
            chk("stream_data", rs_bus.m_data, exp_data);
            state_chk("stream", 1'b1, 1'b1, 2'd1);
         end
         rs_bus.s_valid = 1'b1;
         rs_bus.s_data  = W'(i);
      end
      @(negedge clk);
      chk("stream_last", rs_bus.m_data, 67'h10);
      state_chk("stream_last", 1'b1, 1'b1, 2'd1);
      rs_bus.s_valid = 1'b0;
      @(negedge clk);
      state_chk("stream_drained", 1'b0, 1'b1, 2'd0);

      // Backpressure: 0xA then 0xB with consumer stalled
      rs_bus.m_ready = 1'b0;
      send(67'hA);
      send(67'hB);
      @(negedge clk);
      rs_bus.s_valid = 1'b0;
      state_chk("bp_full", 1'b1, 1'b0, 2'd2);
      chk("bp_full_data", rs_bus.m_data, 67'hA);
      @(negedge clk);
      chk("bp_hold_data", rs_bus.m_data, 67'hA);
      rs_bus.m_ready = 1'b1;
      @(negedge clk);
      chk("bp_second_data", rs_bus.m_data, 67'hB);
      state_chk("bp_busy", 1'b1, 1'b1, 2'd1);
      @(negedge clk);
      state_chk("bp_empty", 1'b0, 1'b1, 2'd0);

      // FULL ignores s_valid; 0xC only taken once s_ready is back
      rs_bus.m_ready = 1'b0;
      send(67'hA);
      send(67'hB);
      send(67'hC);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         state_chk("full_ign", 1'b1, 1'b0, 2'd2);
         chk("full_ign_data", rs_bus.m_data, 67'hA);
      end
      rs_bus.m_ready = 1'b1;
      @(negedge clk);
      chk("full_ign_b", rs_bus.m_data, 67'hB);
      state_chk("full_ign_busy", 1'b1, 1'b1, 2'd1);
      @(negedge clk);
      chk("full_ign_c", rs_bus.m_data, 67'hC);
      state_chk("full_ign_c", 1'b1, 1'b1, 2'd1);
      rs_bus.s_valid = 1'b0;
      @(negedge clk);
      state_chk("full_ign_empty", 1'b0, 1'b1, 2'd0);

      // Asynchronous reset while FULL
      rs_bus.m_ready = 1'b0;
      send(67'hD);
      send(67'hE);
      @(negedge clk);
      rs_bus.s_valid = 1'b0;
      state_chk("pre_rst_full", 1'b1, 1'b0, 2'd2);
      #2;
      rstn = 1'b0;
      #1;
      state_chk("async_rst", 1'b0, 1'b0, 2'd0);
      chk("async_rst_data", rs_bus.m_data, 67'h0);
      @(negedge clk);
      rstn = 1'b1;
      rs_bus.m_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         state_chk("post_rst", 1'b0, 1'b1, 2'd0);
      end

      // Random traffic with scoreboard
      for (int c = 0; c < 10000; c++) begin
         @(negedge clk);
         sr_before      = rs_bus.s_ready;
         rs_bus.s_valid = 1'($urandom_range(0, 1));
         rs_bus.m_ready = 1'($urandom_range(0, 1));
         rs_bus.s_data  = W'({$urandom, $urandom, $urandom});
         #1;
         chk("s_ready_no_comb", rs_bus.s_ready, sr_before);
         if (rs_bus.s_valid && rs_bus.s_ready) sb.push_back(rs_bus.s_data);
         if (rs_bus.m_valid && rs_bus.m_ready) begin
            chk("rand_sb_nonempty", (sb.size() != 0), 1'b1);
            if (sb.size() != 0) chk("rand_order", rs_bus.m_data, sb.pop_front());
         end
      end

      // Drain within a bounded number of cycles
      @(negedge clk);
      rs_bus.s_valid = 1'b0;
      rs_bus.m_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         #1;
         if (rs_bus.m_valid) begin
            chk("drain_sb_nonempty", (sb.size() != 0), 1'b1);
            if (sb.size() != 0) chk("drain_order", rs_bus.m_data, sb.pop_front());
         end
         @(negedge clk);
      end
      chk("drain_sb_empty", sb.size(), 0);
      state_chk("drain_final", 1'b0, 1'b1, 2'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rs_skid_buffer.md
RS_SKID_BUFFER -- requirements
Module: rs_skid_buffer

Interface
REQ-001 SHALL have parameter: payload_len, 67, payload width in bits.
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rstn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: s_valid  input  1  upstream payload valid.
REQ-005 SHALL have port: s_ready  output  1  slice can accept upstream payload.
REQ-006 SHALL have port: s_data  input  payload_len  upstream payload.
REQ-007 SHALL have port: m_valid  output  1  downstream payload valid.
REQ-008 SHALL have port: m_ready  input  1  downstream accepts payload.
REQ-009 SHALL have port: m_data  output  payload_len  downstream payload.
REQ-010 SHALL have port: occupancy  output  2  number of stored entries (0..2).

Function
REQ-011 SHALL hold two payload entries: main (drives m_data) and skid.
REQ-012 SHALL complete an upstream transfer only when s_valid and s_ready are both high at a rising clk edge.
REQ-013 SHALL complete a downstream transfer only when m_valid and m_ready are both high at a rising clk edge.
REQ-014 SHALL drive s_ready, m_valid and occupancy directly from registered state, with no combinational path from m_ready or s_valid.
REQ-015 SHALL use a three-state FSM with states EMPTY (occupancy 0, m_valid 0, s_ready 1), BUSY (occupancy 1, m_valid 1, s_ready 1) and FULL (occupancy 2, m_valid 1, s_ready 0).
REQ-016 SHALL, in EMPTY with s_valid high, load s_data into main and go to BUSY; with s_valid low it SHALL stay in EMPTY and hold main.
REQ-017 SHALL, in BUSY with an upstream and a downstream transfer in the same cycle, load s_data into main and stay in BUSY.
REQ-018 SHALL, in BUSY with an upstream transfer only, load s_data into skid, hold main and go to FULL.
REQ-019 SHALL, in BUSY with a downstream transfer only, go to EMPTY.
REQ-020 SHALL, in BUSY with no transfer, hold both entries and stay in BUSY.
REQ-021 SHALL, in FULL with m_ready high, copy skid into main and go to BUSY; s_valid SHALL be ignored in FULL.
REQ-022 SHALL, in FULL with m_ready low, hold both entries and stay in FULL.
REQ-023 SHALL have 1-cycle latency: a payload accepted at edge N appears on m_data with m_valid high after edge N.
REQ-024 SHALL sustain one transfer per cycle with both sides continuously valid and ready.
REQ-025 SHALL preserve order and SHALL never drop or duplicate a payload.
REQ-026 SHALL hold m_data stable while m_valid is high and m_ready is low.
REQ-027 m_data SHALL be don't-care while m_valid is low.

Reset
REQ-028 SHALL, while rstn is low, asynchronously force state EMPTY, s_ready 0, m_valid 0, occupancy 0, and main and skid to 0.
REQ-029 SHALL raise s_ready at the first rising clk edge after rstn deasserts.
REQ-030 SHALL, when reset is asserted mid-operation in any state, discard stored entries; a transfer in flight in that cycle SHALL be lost.

Structure
REQ-031 SHALL take the FSM state enum (EMPTY/BUSY/FULL) and the default payload width constant from shared package rs_pkg.
REQ-032 SHALL implement each entry as one instance of sub-module rs_data_reg: a payload_len-wide register with load enable, hold otherwise and asynchronous clear.
REQ-033 SHALL place the next-state logic and the entry load/select logic in rs_skid_buffer itself.

Verification
REQ-034 Bench SHALL cover reset release: rstn low 3 cycles then high -> s_ready 0 during reset, 1 after the first edge; m_valid 0; occupancy 0.
REQ-035 Bench SHALL cover streaming: 16 payloads 0x1..0x10 with m_ready held 1 -> identical sequence on m_data at 1 beat/cycle, 1-cycle latency, occupancy stays 1.
REQ-036 Bench SHALL cover backpressure: send 0xA then 0xB with m_ready 0 -> occupancy 2, s_ready 0, m_data 0xA held; raise m_ready -> 0xA then 0xB delivered, return to EMPTY.
REQ-037 Bench SHALL cover FULL ignore: in FULL, drive s_valid with 0xC for 2 cycles -> 0xC not captured; it is accepted only after s_ready rises.
REQ-038 Bench SHALL cover random s_valid/m_ready (10k cycles) -> scoreboard shows in-order, lossless delivery and no combinational path from m_ready to s_ready.
REQ-039 Bench SHALL cover mid-operation reset: assert rstn in FULL -> m_valid 0 and occupancy 0 immediately (asynchronous), no stale payload emitted afterwards.
